// File: rtl/cpl_checker.sv
// Receive-side completion checker for the root-port PIO test path.
// Armed with an expected completion (type, tag, data), it parses completion
// TLPs from the 64-bit receive stream and pulses rx_good/rx_bad one cycle
// after the final beat, or rx_bad when no completion arrives in time.
// Optional statistics counters are enabled by defining CPL_CHK_STATS_EN.
module cpl_checker #(
  parameter int          TCQ            = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic        chk_start,
  input  logic        rx_type,
  input  logic [7:0]  rx_tag,
  input  logic [31:0] rx_data,
  output logic        rx_good,
  output logic        rx_bad,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tvalid,
  output logic        m_axis_rx_tready
`ifdef CPL_CHK_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN_ARMED,
    ST_BEAT1,
    ST_DRAIN_EVAL
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          exp_type_q, exp_type_d;
  logic [7:0]    exp_tag_q, exp_tag_d;
  logic [31:0]   exp_data_q, exp_data_d;
  logic          sop_q, sop_d;
  logic          hdr_cpld_q, hdr_cpld_d;
  logic [2:0]    hdr_status_q, hdr_status_d;
  logic [9:0]    hdr_len_q, hdr_len_d;
  logic          verdict_q, verdict_d;
  logic          good_q, good_d;
  logic          bad_q, bad_d;
  logic          tready_q;
  logic          drop_inc;

  logic          beat;
  logic          sop_beat;
  logic          is_cpl;
  logic          timeout;
  logic          pass;
  logic [TW-1:0] timer_inc;
  logic          unused_ok;

  assign beat      = m_axis_rx_tvalid & tready_q;
  assign sop_beat  = beat & sop_q;
  assign is_cpl    = (m_axis_rx_tdata[31:24] == 8'h4A) || (m_axis_rx_tdata[31:24] == 8'h0A);
  assign timeout   = (timer_q == T_LAST);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + T_ONE;

  // Beat1 carries the tag and the payload DW; header fields were captured on beat0.
  assign pass = (hdr_cpld_q == exp_type_q) && (hdr_status_q == 3'b000) &&
                (m_axis_rx_tdata[15:8] == exp_tag_q) &&
                (!hdr_cpld_q || ((hdr_len_q == 10'd1) && (m_axis_rx_tdata[63:32] == exp_data_q)));

  assign unused_ok = ^{m_axis_rx_tkeep, m_axis_rx_tdata[23:16], (TCQ != 0)};

  assign rx_good          = good_q;
  assign rx_bad           = bad_q;
  assign m_axis_rx_tready = tready_q;

  // Next-state, timer, capture and verdict logic.
  // Mid-packet beats never look like SOP, so a re-arm during a packet drains its
  // remainder through sop tracking alone without a separate drain state.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    exp_type_d   = exp_type_q;
    exp_tag_d    = exp_tag_q;
    exp_data_d   = exp_data_q;
    sop_d        = sop_q;
    hdr_cpld_d   = hdr_cpld_q;
    hdr_status_d = hdr_status_q;
    hdr_len_d    = hdr_len_q;
    verdict_d    = verdict_q;
    good_d       = 1'b0;
    bad_d        = 1'b0;
    drop_inc     = 1'b0;

    if (beat) sop_d = m_axis_rx_tlast;

    case (state_q)
      ST_IDLE: begin
        if (sop_beat) drop_inc = 1'b1;
      end
      ST_ARMED: begin
        timer_d = timer_inc;
        if (timeout) begin
          bad_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (sop_beat) begin
          if (is_cpl) begin
            hdr_cpld_d   = (m_axis_rx_tdata[31:24] == 8'h4A);
            hdr_status_d = m_axis_rx_tdata[47:45];
            hdr_len_d    = m_axis_rx_tdata[9:0];
            if (m_axis_rx_tlast) begin
              bad_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BEAT1;
            end
          end else begin
            drop_inc = 1'b1;
            if (!m_axis_rx_tlast) state_d = ST_DRAIN_ARMED;
          end
        end
      end
      ST_DRAIN_ARMED: begin
        timer_d = timer_inc;
        if (timeout) begin
          bad_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (beat && m_axis_rx_tlast) begin
          state_d = ST_ARMED;
        end
      end
      ST_BEAT1: begin
        if (beat) begin
          verdict_d = pass;
          if (m_axis_rx_tlast) begin
            good_d  = pass;
            bad_d   = !pass;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN_EVAL;
          end
        end
      end
      ST_DRAIN_EVAL: begin
        if (beat && m_axis_rx_tlast) begin
          good_d  = verdict_q;
          bad_d   = !verdict_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new arm overrides the state but not a verdict already being produced.
    if (chk_start) begin
      exp_type_d = rx_type;
      exp_tag_d  = rx_tag;
      exp_data_d = rx_data;
      timer_d    = '0;
      state_d    = ST_ARMED;
    end
  end

  // State and datapath registers.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      exp_type_q   <= 1'b0;
      exp_tag_q    <= '0;
      exp_data_q   <= '0;
      sop_q        <= 1'b1;
      hdr_cpld_q   <= 1'b0;
      hdr_status_q <= '0;
      hdr_len_q    <= '0;
      verdict_q    <= 1'b0;
      good_q       <= 1'b0;
      bad_q        <= 1'b0;
      tready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      exp_type_q   <= exp_type_d;
      exp_tag_q    <= exp_tag_d;
      exp_data_q   <= exp_data_d;
      sop_q        <= sop_d;
      hdr_cpld_q   <= hdr_cpld_d;
      hdr_status_q <= hdr_status_d;
      hdr_len_q    <= hdr_len_d;
      verdict_q    <= verdict_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      tready_q     <= 1'b1;
    end
  end

`ifdef CPL_CHK_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] bad_cnt_q, bad_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign good_cnt = good_cnt_q;
  assign bad_cnt  = bad_cnt_q;
  assign drop_cnt = drop_cnt_q;

  // Saturating event counters.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (good_d && (good_cnt_q != '1)) good_cnt_d = good_cnt_q + 16'd1;
    if (bad_d && (bad_cnt_q != '1))   bad_cnt_d  = bad_cnt_q + 16'd1;
    if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_inc;
`endif

endmodule

// File: tb/tb_cpl_checker.sv
// Self-checking bench for cpl_checker: directed TLP vectors, a transaction-level
// expectation model keyed by cycle, and a per-cycle output comparator.
module tb_cpl_checker;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chk_start = 1'b0;
  logic        rx_type = 1'b0;
  logic [7:0]  rx_tag = '0;
  logic [31:0] rx_data = '0;
  logic        rx_good, rx_bad;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
`ifdef CPL_CHK_STATS_EN
  logic [15:0] good_cnt, bad_cnt, drop_cnt;
`endif

  cpl_checker #(.TCQ(1), .TIMEOUT_CYCLES(T)) dut (
    .user_clk(clk),
    .reset(reset),
    .chk_start(chk_start),
    .rx_type(rx_type),
    .rx_tag(rx_tag),
    .rx_data(rx_data),
    .rx_good(rx_good),
    .rx_bad(rx_bad),
    .m_axis_rx_tdata(tdata),
    .m_axis_rx_tkeep(tkeep),
    .m_axis_rx_tlast(tlast),
    .m_axis_rx_tvalid(tvalid),
    .m_axis_rx_tready(tready)
`ifdef CPL_CHK_STATS_EN
    ,
    .good_cnt(good_cnt),
    .bad_cnt(bad_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Model state: cycles (posedge counts) at which a verdict pulse is due.
  bit          exp_good[int];
  bit          exp_bad[int];
  bit          armed = 1'b0;
  int          to_cyc = 0;
  bit          m_type = 1'b0;
  logic [7:0]  m_tag = '0;
  logic [31:0] m_data = '0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion acceptance rules applied to the raw beats.
  function automatic bit judge(input bit et, input logic [7:0] etag, input logic [31:0] ed,
                               input logic [63:0] b0, input logic [63:0] b1);
    bit cpld;
    bit ok;
    cpld = (b0[31:24] == 8'h4A);
    ok = (cpld == et) && (b0[47:45] == 3'b000) && (b1[15:8] == etag);
    if (cpld) ok = ok && (b0[9:0] == 10'd1) && (b1[63:32] == ed);
    return ok;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_good", rx_good, exp_good.exists(cyc) ? 64'd1 : 64'd0);
      check("rx_bad", rx_bad, exp_bad.exists(cyc) ? 64'd1 : 64'd0);
    end
  end

  task automatic arm(input bit t, input logic [7:0] tag, input logic [31:0] d);
    chk_start = 1'b1; rx_type = t; rx_tag = tag; rx_data = d;
    @(posedge clk); #1;
    chk_start = 1'b0;
    if (armed && to_cyc > cyc) exp_bad.delete(to_cyc);
    armed = 1'b1;
    to_cyc = cyc + T;
    exp_bad[to_cyc] = 1'b1;
    m_type = t; m_tag = tag; m_data = d;
  endtask

  task automatic send_pkt(input logic [63:0] b0, input logic [63:0] b1, input int nbeats,
                          output int last_cyc);
    int s;
    bit cpl;
    bit judged;
    cpl = (b0[31:24] == 8'h4A) || (b0[31:24] == 8'h0A);
    tvalid = 1'b1; tdata = b0; tkeep = 8'hFF; tlast = (nbeats == 1);
    @(posedge clk); #1;
    s = cyc;
    judged = 1'b0;
    if (armed && s < to_cyc) begin
      if (cpl) begin
        exp_bad.delete(to_cyc);
        armed = 1'b0;
        judged = 1'b1;
        if (nbeats == 1) exp_bad[s] = 1'b1;
      end
    end else begin
      armed = 1'b0;
    end
    for (int i = 1; i < nbeats; i++) begin
      tdata = (i == 1) ? b1 : 64'h0;
      tlast = (i == nbeats - 1);
      tkeep = (tlast && b0[31:24] == 8'h0A) ? 8'h0F : 8'hFF;
      @(posedge clk); #1;
    end
    last_cyc = cyc;
    tvalid = 1'b0; tlast = 1'b0;
    if (judged && nbeats > 1) begin
      if (judge(m_type, m_tag, m_data, b0, b1)) exp_good[last_cyc] = 1'b1;
      else exp_bad[last_cyc] = 1'b1;
    end
  endtask

  localparam logic [63:0] CPLD_B0 = 64'h00000000_4A000001;
  localparam logic [63:0] CPLD_B1 = 64'h12345678_00000500;

  initial begin
    int lc;
    int c;
    int first;
`ifdef CPL_CHK_STATS_EN
    logic [15:0] d0, g0;
`endif
    // Model pins.
    check("judge_good", judge(1'b1, 8'h05, 32'h12345678, CPLD_B0, CPLD_B1), 64'd1);
    check("judge_data", judge(1'b1, 8'h05, 32'h12345679, CPLD_B0, CPLD_B1), 64'd0);
    check("judge_ur", judge(1'b1, 8'h05, 32'h12345678, 64'h00002000_4A000001, CPLD_B1), 64'd0);
    check("judge_cpl", judge(1'b0, 8'h21, 32'h0, 64'h00000000_0A000000, 64'h00000000_00002100), 64'd1);

    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_good", rx_good, 0);
    check("rst_bad", rx_bad, 0);
    check("rst_tready", tready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("tready_up", tready, 1);

    // Correct CplD.
    arm(1'b1, 8'h05, 32'h12345678);
    send_pkt(CPLD_B0, CPLD_B1, 2, lc);
    @(negedge clk);
    check("good_lit", {rx_good, rx_bad}, 2'b10);
    check("good_cycle", cyc, lc);

    // Wrong data, wrong tag.
    arm(1'b1, 8'h05, 32'h12345679);
    send_pkt(CPLD_B0, CPLD_B1, 2, lc);
    @(negedge clk);
    check("bad_data_lit", {rx_good, rx_bad}, 2'b01);
    arm(1'b1, 8'h06, 32'h12345678);
    send_pkt(CPLD_B0, CPLD_B1, 2, lc);

    // Timeout.
    arm(1'b1, 8'h05, 32'h12345678);
    c = cyc;
    first = -1;
    for (int i = 0; i < T + 8; i++) begin
      @(negedge clk);
      if (rx_bad && first < 0) first = cyc - c;
    end
    check("timeout_latency", first, T);
    armed = 1'b0;

    // MemWr discarded while armed, then the correct CplD.
`ifdef CPL_CHK_STATS_EN
    d0 = drop_cnt; g0 = good_cnt;
`endif
    arm(1'b1, 8'h05, 32'h12345678);
    send_pkt(64'h00000000_40000001, 64'hDEADBEEF_00000000, 2, lc);
    send_pkt(CPLD_B0, CPLD_B1, 2, lc);
    @(negedge clk);
`ifdef CPL_CHK_STATS_EN
    check("drop_cnt", drop_cnt, d0 + 16'd1);
    check("good_cnt", good_cnt, g0 + 16'd1);
`endif

    // UR status, Cpl pass, Cpl vs CplD type mismatch.
    arm(1'b1, 8'h05, 32'h12345678);
    send_pkt(64'h00002000_4A000001, CPLD_B1, 2, lc);
    arm(1'b0, 8'h21, 32'h0);
    send_pkt(64'h00000000_0A000000, 64'h00000000_00002100, 2, lc);
    arm(1'b1, 8'h21, 32'h0);
    send_pkt(64'h00000000_0A000000, 64'h00000000_00002100, 2, lc);

    // Completion while idle: no pulse.
    send_pkt(CPLD_B0, CPLD_B1, 2, lc);
    repeat (3) @(posedge clk);
    #1;

    // Longer TLPs: held verdicts (bad CplD length 2, good 3-beat Cpl).
    arm(1'b1, 8'h05, 32'h12345678);
    send_pkt(64'h00000000_4A000002, CPLD_B1, 3, lc);
    arm(1'b0, 8'h33, 32'h0);
    send_pkt(64'h00000000_0A000000, 64'h00000000_00003300, 3, lc);

    // Malformed: tlast on beat0 of a completion.
    arm(1'b1, 8'h05, 32'h12345678);
    send_pkt(CPLD_B0, CPLD_B1, 1, lc);

    // Re-arm mid-packet: remainder drained without verdict, next CplD passes.
    arm(1'b1, 8'h05, 32'h12345678);
    tvalid = 1'b1; tdata = CPLD_B0; tlast = 1'b0;
    @(posedge clk); #1;
    tvalid = 1'b0;
    exp_bad.delete(to_cyc);
    armed = 1'b0;
    arm(1'b1, 8'h07, 32'hCAFEF00D);
    tvalid = 1'b1; tdata = 64'hCAFEF00D_00000700; tlast = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
    send_pkt(CPLD_B0, 64'hCAFEF00D_00000700, 2, lc);

    // Reset between beat0 and beat1.
    arm(1'b1, 8'h05, 32'h12345678);
    tvalid = 1'b1; tdata = CPLD_B0; tlast = 1'b0;
    @(posedge clk); #1;
    tvalid = 1'b0;
    reset = 1'b1;
    armed = 1'b0;
    exp_good.delete();
    exp_bad.delete();
    repeat (2) @(negedge clk);
    check("midrst_tready", tready, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("postrst_tready", tready, 1);
    arm(1'b1, 8'h05, 32'h12345678);
    send_pkt(CPLD_B0, CPLD_B1, 2, lc);
    @(negedge clk);
    check("postrst_good_lit", {rx_good, rx_bad}, 2'b10);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
